// File: rtl/nv_nvdla_cacc_dlv_buffer_if.sv
// Handshake bundle between CACC delivery logic, the delivery buffer and SDP.
// The buffer connects through the slave modport. The master modport is the surrounding environment.
interface nv_nvdla_cacc_dlv_buffer_if #(
  parameter int DW = 128
);
  logic          dlv_valid;
  logic          dlv_ready;
  logic [DW-1:0] dlv_data;
  logic          dlv_batch_end;
  logic          dlv_layer_end;
  logic          cacc2sdp_valid;
  logic          cacc2sdp_ready;
  logic [DW+1:0] cacc2sdp_pd;

  modport master (
    output dlv_valid, dlv_data, dlv_batch_end, dlv_layer_end, cacc2sdp_ready,
    input  dlv_ready, cacc2sdp_valid, cacc2sdp_pd
  );

  modport slave (
    input  dlv_valid, dlv_data, dlv_batch_end, dlv_layer_end, cacc2sdp_ready,
    output dlv_ready, cacc2sdp_valid, cacc2sdp_pd
  );
endinterface

// File: rtl/nv_nvdla_cacc_dlv_buffer.sv
// CACC delivery buffer: DEPTH-entry FIFO feeding SDP, with pop credits and ping-pong layer-done interrupts.
// Optional stall counter is enabled by the NVDLA_CACC_DLV_PERF_EN macro.
module nv_nvdla_cacc_dlv_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 128,
  parameter int CW    = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  nv_nvdla_cacc_dlv_buffer_if.slave bus,
  output logic                dlv_pop,
  output logic [1:0]          cacc2glb_done_intr_pd,
  output logic                dlv_layer_pending,
  output logic [CW-1:0]       fifo_lvl,
  input  logic                dlv_stall_clr,
  output logic [31:0]         dlv_stall_cnt
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  FULL_LVL = CW'(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] layer_cnt;
  logic          intr_ptr;
  logic          push;
  logic          pop;
  logic          layer_in;
  logic          layer_out;
  logic [DW+1:0] head;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  // Ready and valid decode only from the registered level, so SDP ready never loops back to dlv_ready.
  assign bus.dlv_ready      = (fifo_lvl != FULL_LVL);
  assign bus.cacc2sdp_valid = (fifo_lvl != '0);

  // Gating with valid keeps uninitialised storage off the output and gives pd=0 while empty or in reset.
  assign head            = bus.cacc2sdp_valid ? mem[rd_ptr] : '0;
  assign bus.cacc2sdp_pd = head;

  assign push      = bus.dlv_valid && bus.dlv_ready;
  assign pop       = bus.cacc2sdp_valid && bus.cacc2sdp_ready;
  assign layer_in  = push && bus.dlv_layer_end;
  assign layer_out = pop && head[DW+1];

  assign dlv_layer_pending = (layer_cnt != '0);

  // NOTE: storage has no reset; occupancy is tracked by fifo_lvl, so resetting wide data flops only costs area.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.dlv_layer_end, bus.dlv_batch_end, bus.dlv_data};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      fifo_lvl              <= '0;
      layer_cnt             <= '0;
      intr_ptr              <= 1'b0;
      dlv_pop               <= 1'b0;
      cacc2glb_done_intr_pd <= 2'b00;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   fifo_lvl <= fifo_lvl + CW'(1);
        2'b01:   fifo_lvl <= fifo_lvl - CW'(1);
        default: fifo_lvl <= fifo_lvl;
      endcase

      case ({layer_in, layer_out})
        2'b10:   layer_cnt <= layer_cnt + CW'(1);
        2'b01:   layer_cnt <= layer_cnt - CW'(1);
        default: layer_cnt <= layer_cnt;
      endcase

      dlv_pop <= pop;

      if (layer_out) begin
        cacc2glb_done_intr_pd <= intr_ptr ? 2'b10 : 2'b01;
        intr_ptr              <= ~intr_ptr;
      end else begin
        cacc2glb_done_intr_pd <= 2'b00;
      end
    end
  end

`ifdef NVDLA_CACC_DLV_PERF_EN
  // Counts cycles where SDP holds off a valid entry; clear wins over increment, count saturates.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dlv_stall_cnt <= '0;
    end else if (dlv_stall_clr) begin
      dlv_stall_cnt <= '0;
    end else if (bus.cacc2sdp_valid && !bus.cacc2sdp_ready && (dlv_stall_cnt != '1)) begin
      dlv_stall_cnt <= dlv_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_stall_clr;
  assign unused_stall_clr = dlv_stall_clr;
  assign dlv_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_dlv_buffer.sv
// Directed bench for the CACC delivery buffer (DEPTH=8, DW=128).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_nv_nvdla_cacc_dlv_buffer;
  localparam int DEPTH = 8;
  localparam int DW    = 128;
  localparam int CW    = 4;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          dlv_pop;
  logic [1:0]    intr;
  logic          pending;
  logic [CW-1:0] lvl;
  logic          stall_clr = 1'b0;
  logic [31:0]   stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [DW+1:0] model_q [$];

  always #5 clk = ~clk;

  nv_nvdla_cacc_dlv_buffer_if #(.DW(DW)) bus ();

  nv_nvdla_cacc_dlv_buffer #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .bus                   (bus),
    .dlv_pop               (dlv_pop),
    .cacc2glb_done_intr_pd (intr),
    .dlv_layer_pending     (pending),
    .fifo_lvl              (lvl),
    .dlv_stall_clr         (stall_clr),
    .dlv_stall_cnt         (stall_cnt)
  );

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW+1:0] ent(input logic le, input logic be, input logic [DW-1:0] d);
    return {le, be, d};
  endfunction

  task automatic drive(input logic v, input logic le, input logic be, input logic [DW-1:0] d);
    bus.dlv_valid     = v;
    bus.dlv_layer_end = le;
    bus.dlv_batch_end = be;
    bus.dlv_data      = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   bus.dlv_ready,      1);
    check({tag, "_valid"},   bus.cacc2sdp_valid, 0);
    check({tag, "_pd"},      bus.cacc2sdp_pd,    0);
    check({tag, "_pop"},     dlv_pop,            0);
    check({tag, "_intr"},    intr,               0);
    check({tag, "_pending"}, pending,            0);
    check({tag, "_lvl"},     lvl,                0);
  endtask

  initial begin
    logic [DW+1:0] e;
    drive(1'b0, 1'b0, 1'b0, 'x);
    bus.cacc2sdp_ready = 1'b0;

    // Reset state (X on dlv_data while dlv_valid=0 must not reach pd)
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_stall", stall_cnt, 0);
    @(negedge clk) rstn = 1'b1;
    tick();
    check("idle_valid", bus.cacc2sdp_valid, 0);
    check("idle_pd", bus.cacc2sdp_pd, 0);

    // Single layer_end entry: no bypass, visible next cycle, one pop and one bit0 interrupt
    e = ent(1'b1, 1'b0, {16{8'hA5}});
    drive(1'b1, 1'b1, 1'b0, {16{8'hA5}});
    bus.cacc2sdp_ready = 1'b1;
    #1 check("single_nobypass", bus.cacc2sdp_valid, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 'x);
    check("single_valid", bus.cacc2sdp_valid, 1);
    check("single_pd", bus.cacc2sdp_pd, e);
    check("single_pd129", bus.cacc2sdp_pd[DW+1], 1);
    check("single_pending", pending, 1);
    check("single_lvl", lvl, 1);
    tick();
    check("single_pop", dlv_pop, 1);
    check("single_intr", intr, 2'b01);
    check("single_empty", bus.cacc2sdp_valid, 0);
    check("single_pending0", pending, 0);
    tick();
    check("single_pop_once", dlv_pop, 0);
    check("single_intr_once", intr, 2'b00);

    // Fill to DEPTH with SDP stalled, 9th push ignored, then drain in order
    bus.cacc2sdp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(256 + i));
      tick();
    end
    check("fill_lvl", lvl, 8);
    check("fill_ready", bus.dlv_ready, 0);
    drive(1'b1, 1'b1, 1'b1, DW'(32'hDEAD));
    tick();
    drive(1'b0, 1'b0, 1'b0, 'x);
    check("fill_9th_lvl", lvl, 8);
    check("fill_9th_pending", pending, 0);
    check("fill_hold_pd", bus.cacc2sdp_pd, ent(1'b0, 1'b0, DW'(256)));
    bus.cacc2sdp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_pd%0d", i), bus.cacc2sdp_pd, ent(1'b0, 1'b0, DW'(256 + i)));
      tick();
      check($sformatf("drain_pop%0d", i), dlv_pop, 1);
    end
    check("drain_lvl", lvl, 0);
    check("drain_ready", bus.dlv_ready, 1);
    tick();
    check("drain_pop_end", dlv_pop, 0);

    // Simultaneous push/pop at level 3 for 10 cycles, pointers wrap
    bus.cacc2sdp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(512 + k));
      model_q.push_back(ent(1'b0, 1'b0, DW'(512 + k)));
      tick();
    end
    check("sim_lvl_start", lvl, 3);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, (c % 2) == 1, DW'(768 + c));
      bus.cacc2sdp_ready = 1'b1;
      check($sformatf("sim_head%0d", c), bus.cacc2sdp_pd, model_q[0]);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(ent(1'b0, (c % 2) == 1, DW'(768 + c)));
      check($sformatf("sim_lvl%0d", c), lvl, 3);
    end
    drive(1'b0, 1'b0, 1'b0, 'x);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sim_tail%0d", k), bus.cacc2sdp_pd, model_q.pop_front());
      tick();
    end
    check("sim_lvl_end", lvl, 0);
    check("sim_no_intr", intr, 2'b00);

    // Asynchronous reset mid-stream with 5 entries, 2 of them layer_end
    bus.cacc2sdp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, (k == 0) || (k == 2), 1'b0, DW'(1024 + k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 'x);
    check("mid_lvl", lvl, 5);
    check("mid_pending", pending, 1);
    bus.cacc2sdp_ready = 1'b1;
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    tick();
    check_reset_outputs("post_rst1");
    tick();
    check("post_rst2_pop", dlv_pop, 0);
    check("post_rst2_intr", intr, 2'b00);

    // Ping-pong: L, batch-only, L, L -> bit0, none, bit1, bit0
    bus.cacc2sdp_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, DW'(1)); tick();
    drive(1'b1, 1'b0, 1'b1, DW'(2)); tick();
    drive(1'b1, 1'b1, 1'b0, DW'(3)); tick();
    drive(1'b1, 1'b1, 1'b1, DW'(4)); tick();
    drive(1'b0, 1'b0, 1'b0, 'x);
    check("pp_pending_full", pending, 1);
    bus.cacc2sdp_ready = 1'b1;
    tick();
    check("pp_intr1", intr, 2'b01);
    check("pp_pending1", pending, 1);
    tick();
    check("pp_intr_batch", intr, 2'b00);
    check("pp_pending2", pending, 1);
    tick();
    check("pp_intr2", intr, 2'b10);
    check("pp_pending3", pending, 1);
    tick();
    check("pp_intr3", intr, 2'b01);
    check("pp_pending4", pending, 0);
    tick();
    check("pp_intr_quiet", intr, 2'b00);

    // Stall counter: clear, 37 stalled cycles, clear again
    bus.cacc2sdp_ready = 1'b0;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("perf_clr0", stall_cnt, 0);
    drive(1'b1, 1'b0, 1'b0, DW'(9));
    tick();
    drive(1'b0, 1'b0, 1'b0, 'x);
    check("perf_start", stall_cnt, 0);
    repeat (37) tick();
`ifdef NVDLA_CACC_DLV_PERF_EN
    check("perf_37", stall_cnt, 37);
`else
    check("perf_off", stall_cnt, 0);
`endif
    stall_clr = 1'b1;
    tick();
    check("perf_clr", stall_cnt, 0);
    stall_clr = 1'b0;
    bus.cacc2sdp_ready = 1'b1;
    tick();
    check("perf_after_pop", stall_cnt, 0);
    check("perf_pop", dlv_pop, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
